// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: bus bundle between the unified memory arbiter and its
// requesters (fetch F, load/store D, external E) plus the single memory port.
//   slave  modport : arbiter side (takes requests and memory read data, drives
//                    grants, responses, memory controls and e_starved_o)
//   master modport : requester/memory side (the mirror image)
interface unified_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    // fetch port (read only)
    logic            f_req_i;
    logic [XLEN-1:0] f_addr_i;
    logic            f_gnt_o;
    logic            f_rvalid_o;
    logic [XLEN-1:0] f_rdata_o;

    // load/store port
    logic            d_req_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_addr_i;
    logic [XLEN-1:0] d_wdata_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;

    // external debug/loader port
    logic            e_req_i;
    logic            e_we_i;
    logic [XLEN-1:0] e_addr_i;
    logic [XLEN-1:0] e_wdata_i;
    logic            e_gnt_o;
    logic            e_rvalid_o;
    logic [XLEN-1:0] e_rdata_o;
    logic            e_starved_o;

    // unified memory port
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  f_req_i, f_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  e_req_i, e_we_i, e_addr_i, e_wdata_i,
        input  mem_rdata_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output e_gnt_o, e_rvalid_o, e_rdata_o, e_starved_o,
        output mem_addr_o, mem_wdata_o, mem_we_o
    );

    modport master (
        output f_req_i, f_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output e_req_i, e_we_i, e_addr_i, e_wdata_i,
        output mem_rdata_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  e_gnt_o, e_rvalid_o, e_rdata_o, e_starved_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: per-cycle arbiter sharing one unified instruction+data
// memory between core fetch (F), core load/store (D) and an external port (E).
// At most one access is granted per cycle; the winner drives the memory port and
// its response (read data or store ack) returns exactly one cycle later.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset
//   bus    - unified_mem_arbiter_if.slave (all request/response/memory signals)
//
// Configuration macro: UNIFIED_MEM_ARB_EXT_EN
//   defined   : E port active, normal priority D > F > E, boosted E > D > F
//               after MAX_WAIT consecutive denied cycles.
//   undefined : E inputs ignored, E outputs tied 0, fixed priority D > F.
module unified_mem_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    unified_mem_arbiter_if.slave   bus
);
    localparam int unsigned WAIT_W = 4;

    // Winner flags for the current cycle
    logic f_win;
    logic d_win;
    logic e_win;

    // Registered responses
    logic            f_rvalid_q;
    logic [XLEN-1:0] f_rdata_q;
    logic            d_rvalid_q;
    logic [XLEN-1:0] d_rdata_q;

`ifdef UNIFIED_MEM_ARB_EXT_EN
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              boost;
    logic              e_starved_q;
    logic              e_rvalid_q;
    logic [XLEN-1:0]   e_rdata_q;

    assign boost = (wait_cnt == MAX_WAIT_C);
`else
    // External port is compiled out; its inputs are intentionally unused.
    logic unused_ext;
    assign unused_ext = ^{bus.e_req_i, bus.e_we_i, bus.e_addr_i, bus.e_wdata_i,
                          WAIT_W'(MAX_WAIT)};
`endif

    // Priority select; grants are held off while reset is asserted.
    always_comb begin
        f_win = 1'b0;
        d_win = 1'b0;
        e_win = 1'b0;
        if (!rst_i) begin
`ifdef UNIFIED_MEM_ARB_EXT_EN
            if (boost && bus.e_req_i) begin
                e_win = 1'b1;
            end else if (bus.d_req_i) begin
                d_win = 1'b1;
            end else if (bus.f_req_i) begin
                f_win = 1'b1;
            end else if (bus.e_req_i) begin
                e_win = 1'b1;
            end
`else
            if (bus.d_req_i) begin
                d_win = 1'b1;
            end else if (bus.f_req_i) begin
                f_win = 1'b1;
            end
`endif
        end
    end

    // Memory port mux; all zero when nobody wins.
    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_we_o    = 1'b0;
        if (d_win) begin
            bus.mem_addr_o  = bus.d_addr_i;
            bus.mem_wdata_o = bus.d_wdata_i;
            bus.mem_we_o    = bus.d_we_i;
        end else if (f_win) begin
            bus.mem_addr_o  = bus.f_addr_i;
`ifdef UNIFIED_MEM_ARB_EXT_EN
        end else if (e_win) begin
            bus.mem_addr_o  = bus.e_addr_i;
            bus.mem_wdata_o = bus.e_wdata_i;
            bus.mem_we_o    = bus.e_we_i;
`endif
        end
    end

`ifdef UNIFIED_MEM_ARB_EXT_EN
    // Starvation counter: counts consecutive denied E cycles, saturating.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!bus.e_req_i || e_win) begin
            wait_nxt = '0;
        end else if (wait_cnt != MAX_WAIT_C) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end
`endif

    // Response registers: one-cycle rvalid pulse, rdata held until next response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_rvalid_q  <= 1'b0;
            f_rdata_q   <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
`ifdef UNIFIED_MEM_ARB_EXT_EN
            e_rvalid_q  <= 1'b0;
            e_rdata_q   <= '0;
            wait_cnt    <= '0;
            e_starved_q <= 1'b0;
`endif
        end else begin
            f_rvalid_q <= f_win;
            d_rvalid_q <= d_win;
            if (f_win) begin
                f_rdata_q <= bus.mem_rdata_i;
            end
            if (d_win) begin
                d_rdata_q <= bus.d_we_i ? '0 : bus.mem_rdata_i;
            end
`ifdef UNIFIED_MEM_ARB_EXT_EN
            e_rvalid_q <= e_win;
            if (e_win) begin
                e_rdata_q <= bus.e_we_i ? '0 : bus.mem_rdata_i;
            end
            wait_cnt    <= wait_nxt;
            // Tracks wait_cnt == MAX_WAIT from the same edge the counter moves.
            e_starved_q <= (wait_nxt == MAX_WAIT_C);
`endif
        end
    end

    assign bus.f_gnt_o    = f_win;
    assign bus.f_rvalid_o = f_rvalid_q;
    assign bus.f_rdata_o  = f_rdata_q;
    assign bus.d_gnt_o    = d_win;
    assign bus.d_rvalid_o = d_rvalid_q;
    assign bus.d_rdata_o  = d_rdata_q;

`ifdef UNIFIED_MEM_ARB_EXT_EN
    assign bus.e_gnt_o     = e_win;
    assign bus.e_rvalid_o  = e_rvalid_q;
    assign bus.e_rdata_o   = e_rdata_q;
    assign bus.e_starved_o = e_starved_q;
`else
    assign bus.e_gnt_o     = e_win;
    assign bus.e_rvalid_o  = 1'b0;
    assign bus.e_rdata_o   = '0;
    assign bus.e_starved_o = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed self-checking bench for unified_mem_arbiter.
// A small word-addressed memory model answers mem_* combinationally and commits
// stores on the clock edge; expected values are hand-computed constants.
module tb_unified_mem_arbiter;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    unified_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    unified_mem_arbiter #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: 1024 words, addressed by mem_addr_o[11:2].
    logic [31:0] mem [0:1023];
    assign bus.mem_rdata_i = mem[bus.mem_addr_o[11:2]];
    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o[11:2]] <= bus.mem_wdata_o;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[0]            = 32'h00000013;

        // All requesters active while reset is held for two cycles
        bus.f_req_i = 1'b1; bus.f_addr_i = 32'h000;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100; bus.d_wdata_i = 32'h0;
        bus.e_req_i = 1'b1; bus.e_we_i = 1'b0; bus.e_addr_i = 32'h040; bus.e_wdata_i = 32'h0;

        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_f_gnt",   32'(bus.f_gnt_o), 32'd0);
            check("rst_d_gnt",   32'(bus.d_gnt_o), 32'd0);
            check("rst_e_gnt",   32'(bus.e_gnt_o), 32'd0);
            check("rst_mem_we",  32'(bus.mem_we_o), 32'd0);
            check("rst_mem_addr", bus.mem_addr_o, 32'h0);
            check("rst_rvalid",  32'({bus.f_rvalid_o, bus.d_rvalid_o, bus.e_rvalid_o}), 32'd0);
            check("rst_rdata",   bus.f_rdata_o | bus.d_rdata_o | bus.e_rdata_o, 32'h0);
            check("rst_starved", 32'(bus.e_starved_o), 32'd0);
        end

        // Release: D load 0x100 and F fetch 0x000 together, D wins
        rst = 1'b0;
        bus.e_req_i = 1'b0;
        settle();
        check("dl_d_gnt",    32'(bus.d_gnt_o), 32'd1);
        check("dl_f_gnt",    32'(bus.f_gnt_o), 32'd0);
        check("dl_mem_addr", bus.mem_addr_o, 32'h100);
        check("dl_mem_we",   32'(bus.mem_we_o), 32'd0);
        tick();
        bus.d_req_i = 1'b0;
        settle();
        check("dl_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
        check("dl_d_rdata",  bus.d_rdata_o, 32'hDEADBEEF);
        check("dl_f_gnt2",   32'(bus.f_gnt_o), 32'd1);
        check("dl_f_addr",   bus.mem_addr_o, 32'h000);
        tick();
        bus.f_req_i = 1'b0;
        check("f_rvalid",    32'(bus.f_rvalid_o), 32'd1);
        check("f_rdata",     bus.f_rdata_o, 32'h00000013);
        check("f_d_rvalid0", 32'(bus.d_rvalid_o), 32'd0);
        settle();
        check("idle_mem_addr", bus.mem_addr_o, 32'h0);
        check("idle_gnt", 32'({bus.f_gnt_o, bus.d_gnt_o, bus.e_gnt_o}), 32'd0);

        // D store 0x55AA55AA to 0x40, then load it back-to-back
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h040; bus.d_wdata_i = 32'h55AA55AA;
        settle();
        check("st_d_gnt",     32'(bus.d_gnt_o), 32'd1);
        check("st_mem_we",    32'(bus.mem_we_o), 32'd1);
        check("st_mem_wdata", bus.mem_wdata_o, 32'h55AA55AA);
        check("st_mem_addr",  bus.mem_addr_o, 32'h040);
        tick();
        bus.d_we_i = 1'b0; bus.d_wdata_i = 32'h0;
        settle();
        check("ld_mem_we",    32'(bus.mem_we_o), 32'd0);
        check("ld_d_gnt",     32'(bus.d_gnt_o), 32'd1);
        check("st_ack",       32'(bus.d_rvalid_o), 32'd1);
        check("st_ack_rdata", bus.d_rdata_o, 32'h0);
        tick();
        bus.d_req_i = 1'b0;
        check("ld_rvalid", 32'(bus.d_rvalid_o), 32'd1);
        check("ld_rdata",  bus.d_rdata_o, 32'h55AA55AA);
        tick();
        check("ld_rvalid_end", 32'(bus.d_rvalid_o), 32'd0);
        check("ld_rdata_hold", bus.d_rdata_o, 32'h55AA55AA);

`ifdef UNIFIED_MEM_ARB_EXT_EN
        // Starvation: D and F always requesting, E reading 0x40
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h100;
        bus.f_req_i = 1'b1; bus.f_addr_i = 32'h000;
        bus.e_req_i = 1'b1; bus.e_we_i = 1'b0; bus.e_addr_i = 32'h040;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("sv_e_gnt_c%0d", c), 32'(bus.e_gnt_o), 32'd0);
            check($sformatf("sv_d_gnt_c%0d", c), 32'(bus.d_gnt_o), 32'd1);
            check($sformatf("sv_starved_c%0d", c), 32'(bus.e_starved_o), 32'd0);
            tick();
        end
        settle();
        check("sv_starved", 32'(bus.e_starved_o), 32'd1);
        check("sv_e_gnt",   32'(bus.e_gnt_o), 32'd1);
        check("sv_d_gnt",   32'(bus.d_gnt_o), 32'd0);
        check("sv_mem_addr", bus.mem_addr_o, 32'h040);
        tick();
        bus.e_req_i = 1'b0;
        check("sv_e_rvalid", 32'(bus.e_rvalid_o), 32'd1);
        check("sv_e_rdata",  bus.e_rdata_o, 32'h55AA55AA);
        check("sv_cleared",  32'(bus.e_starved_o), 32'd0);
        check("sv_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
        bus.d_req_i = 1'b0; bus.f_req_i = 1'b0;
        tick();

        // Reset asserted in the grant cycle of an E read
        bus.e_req_i = 1'b1; bus.e_addr_i = 32'h100;
        settle();
        check("er_e_gnt", 32'(bus.e_gnt_o), 32'd1);
        rst = 1'b1;
        settle();
        check("er_gnt_in_rst", 32'(bus.e_gnt_o), 32'd0);
        tick();
        check("er_e_rvalid", 32'(bus.e_rvalid_o), 32'd0);
        check("er_e_rdata",  bus.e_rdata_o, 32'h0);
        rst = 1'b0; bus.e_req_i = 1'b0;
        tick();
        check("er_e_rvalid2", 32'(bus.e_rvalid_o), 32'd0);
        check("er_e_rdata2",  bus.e_rdata_o, 32'h0);
`else
        // External port compiled out: E requests a store continuously, never wins
        bus.e_req_i = 1'b1; bus.e_we_i = 1'b1; bus.e_addr_i = 32'h040; bus.e_wdata_i = 32'hFFFFFFFF;
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h100;
        bus.f_req_i = 1'b1; bus.f_addr_i = 32'h000;
        for (int c = 1; c <= 6; c++) begin
            settle();
            check($sformatf("off_e_gnt_c%0d", c), 32'(bus.e_gnt_o), 32'd0);
            check($sformatf("off_d_gnt_c%0d", c), 32'(bus.d_gnt_o), 32'd1);
            check($sformatf("off_starved_c%0d", c), 32'(bus.e_starved_o), 32'd0);
            tick();
            check($sformatf("off_d_rdata_c%0d", c), bus.d_rdata_o, 32'hDEADBEEF);
        end
        bus.d_req_i = 1'b0;
        settle();
        check("off_f_gnt",  32'(bus.f_gnt_o), 32'd1);
        check("off_e_gnt",  32'(bus.e_gnt_o), 32'd0);
        tick();
        bus.f_req_i = 1'b0;
        check("off_f_rvalid", 32'(bus.f_rvalid_o), 32'd1);
        check("off_e_rvalid", 32'(bus.e_rvalid_o), 32'd0);
        check("off_e_rdata",  bus.e_rdata_o, 32'h0);
        settle();
        check("off_idle_gnt", 32'(bus.e_gnt_o), 32'd0);
        check("off_idle_we",  32'(bus.mem_we_o), 32'd0);
        tick();
        bus.e_req_i = 1'b0;
        // E store never reached memory
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h040;
        tick();
        bus.d_req_i = 1'b0;
        check("off_mem_intact", bus.d_rdata_o, 32'h55AA55AA);
`endif

        // Reset asserted in the grant cycle of a D read
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100;
        settle();
        check("dr_d_gnt", 32'(bus.d_gnt_o), 32'd1);
        rst = 1'b1;
        settle();
        check("dr_gnt_in_rst", 32'(bus.d_gnt_o), 32'd0);
        tick();
        check("dr_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
        check("dr_d_rdata",  bus.d_rdata_o, 32'h0);
        check("dr_f_rdata",  bus.f_rdata_o, 32'h0);
        rst = 1'b0; bus.d_req_i = 1'b0;
        tick();
        check("dr_d_rvalid2", 32'(bus.d_rvalid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
